// File: rtl/qm_fetch_if.sv
// Instruction-memory req/ack bus between qm_fetch (master) and the memory (slave).
// The address is held stable from request to ack; the memory answers with data in the ack cycle.
interface qm_fetch_if;
  logic [31:0] im_addr;
  logic        im_req;
  logic        im_ack;
  logic [31:0] im_data;

  modport master (output im_addr, output im_req, input im_ack, input im_data);
  modport slave  (input im_addr, input im_req, output im_ack, output im_data);
endinterface

// File: rtl/qm_fetch.sv
// Fetch stage plus IF/ID register: one word per cycle with zero-wait memory, a one-entry hold
// buffer absorbs a word that lands during a decode stall, and redirects flush (or kill an in-flight fetch).
module qm_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] NOP      = 32'h00000000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              ci_Stall,
  input  logic              ci_Branch,
  input  logic [31:0]       di_BranchTarget,
  qm_fetch_if.master        im,
  output logic [31:0]       do_IR,
  output logic [31:0]       do_NextPC,
  output logic              do_Valid
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_KILL} state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] kill_tgt, kill_tgt_d;
  logic [31:0] hold_ir, hold_ir_d;
  logic [31:0] hold_npc, hold_npc_d;
  logic [31:0] ir_d, npc_d;
  logic        vld_d;
  logic        pend, pend_d;
  logic [31:0] target, pc_inc;
  logic        req, done;

  assign target     = di_BranchTarget & ~32'h3;
  assign pc_inc     = pc + 32'd4;
  assign req        = (state != S_HOLD);
  assign done       = req & im.im_ack;
  assign im.im_req  = req & ~sys_rst;
  assign im.im_addr = pc;

  always_comb begin
    state_d    = state;
    pc_d       = pc;
    kill_tgt_d = kill_tgt;
    hold_ir_d  = hold_ir;
    hold_npc_d = hold_npc;
    ir_d       = do_IR;
    npc_d      = do_NextPC;
    vld_d      = do_Valid;
    pend_d     = 1'b0;

    if (ci_Branch) begin
      ir_d      = NOP;
      vld_d     = 1'b0;
      hold_ir_d = NOP;
    end

    case (state)
      S_REQ: begin
        if (ci_Branch) begin
          // An address already held across an edge must see its ack before we move on.
          if (!done && pend) begin
            kill_tgt_d = target;
            state_d    = S_KILL;
          end else begin
            pc_d = target;
          end
        end else if (done) begin
          pc_d = pc_inc;
          if (!ci_Stall) begin
            ir_d  = im.im_data;
            vld_d = 1'b1;
            npc_d = pc_inc;
          end else begin
            hold_ir_d  = im.im_data;
            hold_npc_d = pc_inc;
            state_d    = S_HOLD;
          end
        end else begin
          pend_d = 1'b1;
          if (!ci_Stall) begin
            ir_d  = NOP;
            vld_d = 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (ci_Branch) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (!ci_Stall) begin
          ir_d      = hold_ir;
          vld_d     = 1'b1;
          npc_d     = hold_npc;
          hold_ir_d = NOP;
          state_d   = S_REQ;
        end
      end
      S_KILL: begin
        if (ci_Branch) kill_tgt_d = target;
        if (done) begin
          pc_d    = ci_Branch ? target : kill_tgt;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      kill_tgt  <= 32'h0;
      hold_ir   <= NOP;
      hold_npc  <= 32'h0;
      do_IR     <= NOP;
      do_NextPC <= 32'h0;
      do_Valid  <= 1'b0;
      pend      <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      kill_tgt  <= kill_tgt_d;
      hold_ir   <= hold_ir_d;
      hold_npc  <= hold_npc_d;
      do_IR     <= ir_d;
      do_NextPC <= npc_d;
      do_Valid  <= vld_d;
      pend      <= pend_d;
    end
  end

endmodule

// File: tb/tb_qm_fetch.sv
// Bench for qm_fetch: wait-state memory, transactional fetch/delivery model and directed scenarios.
module tb_qm_fetch;

  localparam logic [31:0] RPC = 32'hBFC00000;
  localparam logic [31:0] NOPW = 32'h00000000;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        ci_Stall = 1'b0;
  logic        ci_Branch = 1'b0;
  logic [31:0] di_BranchTarget = 32'h0;
  logic [31:0] do_IR, do_NextPC;
  logic        do_Valid;
  int          errors = 0;
  int          checks = 0;
  int          ws = 0;
  int          cnt;

  qm_fetch_if bus ();

  qm_fetch #(.RESET_PC(RPC), .NOP(NOPW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ci_Stall(ci_Stall), .ci_Branch(ci_Branch),
    .di_BranchTarget(di_BranchTarget), .im(bus.master),
    .do_IR(do_IR), .do_NextPC(do_NextPC), .do_Valid(do_Valid)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] mw(input logic [31:0] a);
    case (a)
      32'hBFC00000: mw = 32'h00000011;
      32'hBFC00004: mw = 32'h00000022;
      32'hBFC00008: mw = 32'h00000033;
      default:      mw = {a[15:0] ^ 16'h5A5A, a[15:0]};
    endcase
  endfunction

  // Memory answers after ws wait states; the count restarts after each ack or idle cycle.
  assign bus.im_ack  = bus.im_req && (cnt >= ws);
  assign bus.im_data = mw(bus.im_addr);
  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) cnt <= 0;
    else if (!bus.im_req || bus.im_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: fetches complete in program order; each kept word is delivered once decode is free.
  initial begin : cmp
    logic [31:0] exp_fetch, kill_tgt, p_addr, cur_ir, cur_npc, tgt;
    logic        kill, p_req, p_ack, p_br, cur_vld, done, outst;
    logic [63:0] dq[$];
    exp_fetch = RPC; kill_tgt = 0; p_addr = 0; cur_ir = NOPW; cur_npc = 0;
    kill = 0; p_req = 0; p_ack = 0; p_br = 0; cur_vld = 0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        exp_fetch = RPC; kill = 0; dq.delete();
        cur_ir = NOPW; cur_vld = 0; cur_npc = 0; p_req = 0; p_ack = 0; p_br = 0;
        chk("rst_req", {31'b0, bus.im_req}, 32'd0);
        chk("rst_ir", do_IR, NOPW);
        chk("rst_vld", {31'b0, do_Valid}, 32'd0);
        chk("rst_npc", do_NextPC, 32'd0);
      end else begin
        chk("ir", do_IR, cur_ir);
        chk("vld", {31'b0, do_Valid}, {31'b0, cur_vld});
        chk("npc", do_NextPC, cur_npc);
        outst = p_req && !p_ack && !p_br;
        if (bus.im_req) begin
          chk("addr", bus.im_addr, exp_fetch);
          if (outst) chk("addr_stable", bus.im_addr, p_addr);
        end
        tgt  = di_BranchTarget & ~32'h3;
        done = bus.im_req && bus.im_ack;
        if (done && !kill && !ci_Branch) dq.push_back({bus.im_data, bus.im_addr + 32'd4});
        if (done) begin
          if (ci_Branch) exp_fetch = tgt;
          else if (kill) exp_fetch = kill_tgt;
          else exp_fetch = bus.im_addr + 32'd4;
          kill = 0;
        end else if (ci_Branch) begin
          if (bus.im_req && (kill || outst)) begin
            kill = 1; kill_tgt = tgt;
          end else exp_fetch = tgt;
        end
        if (ci_Branch) begin
          dq.delete(); cur_ir = NOPW; cur_vld = 0;
        end else if (!ci_Stall) begin
          if (dq.size() > 0) begin
            {cur_ir, cur_npc} = dq.pop_front();
            cur_vld = 1;
          end else begin
            cur_ir = NOPW; cur_vld = 0;
          end
        end
        p_req = bus.im_req; p_ack = bus.im_ack; p_br = ci_Branch; p_addr = bus.im_addr;
      end
    end
  end

  task automatic reset_dut(input int wstates);
    @(posedge sys_clk); #1;
    sys_rst = 1; ci_Branch = 0; ci_Stall = 0; ws = wstates;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 0;
  endtask

  initial begin : stim
    logic [31:0] la[3];
    logic [31:0] li[3];
    la[0] = 32'hBFC00000; la[1] = 32'hBFC00004; la[2] = 32'hBFC00008;
    li[0] = 32'h11; li[1] = 32'h22; li[2] = 32'h33;

    // 1: zero wait states, one instruction per cycle
    reset_dut(0);
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      if (i < 3) chk("t1_addr", bus.im_addr, la[i]);
      if (i > 0) begin
        chk("t1_ir", do_IR, li[i-1]);
        chk("t1_vld", {31'b0, do_Valid}, 32'd1);
        chk("t1_npc", do_NextPC, la[i-1] + 32'd4);
      end
    end

    // 2: two wait states, address held three cycles, bubbles between words
    reset_dut(2);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      chk("t2_addr", bus.im_addr, RPC);
      chk("t2_ack", {31'b0, bus.im_ack}, (i == 2) ? 32'd1 : 32'd0);
    end
    chk("t2_bubble", {31'b0, do_Valid}, 32'd0);
    @(negedge sys_clk);
    chk("t2_ir", do_IR, 32'h11);
    chk("t2_vld", {31'b0, do_Valid}, 32'd1);
    @(negedge sys_clk);
    chk("t2_bubble2", {31'b0, do_Valid}, 32'd0);

    // 3: stall for 4 cycles while the second word is acked
    reset_dut(0);
    @(posedge sys_clk); #1 ci_Stall = 1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("t3_req_hold", {31'b0, bus.im_req}, 32'd0);
    chk("t3_ir_held", do_IR, 32'h11);
    repeat (3) @(posedge sys_clk);
    #1 ci_Stall = 0;
    @(negedge sys_clk);
    chk("t3_ir_still", do_IR, 32'h11);
    @(negedge sys_clk);
    chk("t3_ir_buf", do_IR, 32'h22);
    chk("t3_npc_buf", do_NextPC, 32'hBFC00008);
    chk("t3_addr_next", bus.im_addr, 32'hBFC00008);

    // 4: redirect to 0x103 while a 3-wait-state fetch is outstanding
    reset_dut(3);
    @(posedge sys_clk); #1 ci_Branch = 1; di_BranchTarget = 32'h00000103;
    @(posedge sys_clk); #1 ci_Branch = 0;
    @(negedge sys_clk);
    chk("t4_old_addr", bus.im_addr, RPC);
    chk("t4_kill_req", {31'b0, bus.im_req}, 32'd1);
    @(negedge sys_clk);
    chk("t4_old_ack", {31'b0, bus.im_ack}, 32'd1);
    @(negedge sys_clk);
    chk("t4_new_addr", bus.im_addr, 32'h00000100);
    chk("t4_vld0", {31'b0, do_Valid}, 32'd0);
    repeat (3) @(negedge sys_clk);
    chk("t4_vld_wait", {31'b0, do_Valid}, 32'd0);
    @(negedge sys_clk);
    chk("t4_ir", do_IR, mw(32'h00000100));
    chk("t4_vld1", {31'b0, do_Valid}, 32'd1);

    // 5: PC wrap from FFFFFFFC
    reset_dut(0);
    ci_Branch = 1; di_BranchTarget = 32'hFFFFFFFC;
    @(posedge sys_clk); #1 ci_Branch = 0;
    @(negedge sys_clk);
    chk("t5_addr_top", bus.im_addr, 32'hFFFFFFFC);
    @(negedge sys_clk);
    chk("t5_addr_wrap", bus.im_addr, 32'h00000000);
    chk("t5_npc_wrap", do_NextPC, 32'h00000000);
    chk("t5_ir", do_IR, mw(32'hFFFFFFFC));

    // 6: branch and stall together, then reset during a wait
    reset_dut(1);
    @(posedge sys_clk); #1 ci_Branch = 1; ci_Stall = 1; di_BranchTarget = 32'h00000200;
    @(posedge sys_clk); #1 ci_Branch = 0; ci_Stall = 0;
    @(negedge sys_clk);
    chk("t6_addr", bus.im_addr, 32'h00000200);
    chk("t6_vld", {31'b0, do_Valid}, 32'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("t6_pre_vld", {31'b0, do_Valid}, 32'd1);
    #2 sys_rst = 1;
    #1;
    chk("t6_rst_req", {31'b0, bus.im_req}, 32'd0);
    chk("t6_rst_vld", {31'b0, do_Valid}, 32'd0);
    @(posedge sys_clk);
    @(posedge sys_clk); #1 sys_rst = 0;
    repeat (6) @(negedge sys_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
